// File: rtl/clock_period_meter_if.sv
// clock_period_meter_if: groups the measured signal and the measurement results.
// master: the meter (samples sig_in, drives the results).
// slave: the environment (drives sig_in, consumes the results).
interface clock_period_meter_if #(
  parameter int count_width = 27
) ();
  logic                   sig_in;
  logic [count_width-1:0] period;
  logic                   period_valid;
  logic                   timeout;

  modport master (
    input  sig_in,
    output period,
    output period_valid,
    output timeout
  );

  modport slave (
    output sig_in,
    input  period,
    input  period_valid,
    input  timeout
  );
endinterface

// File: rtl/clock_period_meter.sv
// clock_period_meter: measures the rising-edge-to-rising-edge period of a slow,
// asynchronous square wave in clock_in cycles, with a sticky timeout flag.
// Optional feature: define GLITCH_FILTER_EN to insert a glitch filter that
// requires filter_len consecutive differing samples before the level changes.
module clock_period_meter #(
  parameter int count_width    = 27,
  parameter int timeout_cycles = 50000000,
  parameter int filter_len     = 3
) (
  input  logic                    clock_in,
  input  logic                    reset_n,
  clock_period_meter_if.master    bus
);

  // Elaboration-time parameter sanity checks.
  if (timeout_cycles < 2) begin : g_bad_timeout
    $error("clock_period_meter: timeout_cycles must be >= 2");
  end
  if (filter_len < 2 || filter_len > 15) begin : g_bad_filter_len
    $error("clock_period_meter: filter_len must be in 2..15");
  end

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [count_width-1:0] TIMEOUT_LAST = count_width'(timeout_cycles - 1);
  localparam logic [count_width-1:0] CNT_ONE      = count_width'(1);

  logic                   s1_reg;
  logic                   s2_reg;
  logic                   lvl;
  logic                   lvl_d_reg;
  logic                   rise;

  state_t                 state_reg, state_next;
  logic [count_width-1:0] cnt_reg, cnt_next;
  logic [count_width-1:0] period_reg, period_next;
  logic                   valid_reg, valid_next;
  logic                   timeout_reg, timeout_next;

  // Two-flop synchronizer bringing sig_in into the clock_in domain.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
    end else begin
      s1_reg <= bus.sig_in;
      s2_reg <= s1_reg;
    end
  end

`ifdef GLITCH_FILTER_EN
  logic       lvl_reg;
  logic [3:0] filt_cnt_reg;

  // Glitch filter: the level follows s2 only after filter_len consecutive
  // cycles of disagreement; any agreeing sample restarts the run.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      lvl_reg      <= 1'b0;
      filt_cnt_reg <= 4'd0;
    end else if (s2_reg == lvl_reg) begin
      filt_cnt_reg <= 4'd0;
    end else if (filt_cnt_reg == 4'(filter_len - 1)) begin
      lvl_reg      <= s2_reg;
      filt_cnt_reg <= 4'd0;
    end else begin
      filt_cnt_reg <= filt_cnt_reg + 4'd1;
    end
  end

  assign lvl = lvl_reg;
`else
  assign lvl = s2_reg;
`endif

  // Delayed copy of the conditioned level for rising-edge detection.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      lvl_d_reg <= 1'b0;
    end else begin
      lvl_d_reg <= lvl;
    end
  end

  assign rise = lvl & ~lvl_d_reg;

  // Measurement state, counter and result registers.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      period_reg  <= '0;
      valid_reg   <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      period_reg  <= period_next;
      valid_reg   <= valid_next;
      timeout_reg <= timeout_next;
    end
  end

  // Next-state logic: a rise in MEASURE captures cnt+1 and takes priority
  // over the timeout, so an edge landing exactly on the limit still reports.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    period_next  = period_reg;
    valid_next   = 1'b0;
    timeout_next = timeout_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (rise) begin
          state_next   = MEASURE;
          timeout_next = 1'b0;
        end
      end
      MEASURE: begin
        if (rise) begin
          period_next = cnt_reg + CNT_ONE;
          valid_next  = 1'b1;
          cnt_next    = '0;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
          cnt_next     = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign bus.period       = period_reg;
  assign bus.period_valid = valid_reg;
  assign bus.timeout      = timeout_reg;

endmodule

// File: tb/tb_clock_period_meter.sv
// tb_clock_period_meter: directed test of clock_period_meter with
// timeout_cycles=20, filter_len=3; works with or without GLITCH_FILTER_EN.
module tb_clock_period_meter;

  localparam int CW = 8;
  localparam int TO = 20;
  localparam int FL = 3;

  logic clock_in;
  logic reset_n;

  clock_period_meter_if #(.count_width(CW)) bus_if ();

  clock_period_meter #(
    .count_width    (CW),
    .timeout_cycles (TO),
    .filter_len     (FL)
  ) dut (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .bus      (bus_if)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  int n_checks = 0;
  int n_pass   = 0;

  // Every captured period (one entry per cycle with period_valid high).
  logic [CW-1:0] vq[$];

  always @(negedge clock_in) begin
    if (reset_n && bus_if.period_valid) vq.push_back(bus_if.period);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock_in);
      #1;
    end
  endtask

  // Square wave: hi cycles high then lo cycles low, repeated n times.
  task automatic wave(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      bus_if.sig_in = 1'b1;
      cyc(hi);
      bus_if.sig_in = 1'b0;
      cyc(lo);
    end
  endtask

  task automatic check_vq(input string tag, input int exp_n, input logic [31:0] e0,
                          input logic [31:0] e1, input logic [31:0] e2,
                          input logic [31:0] e3, input logic [31:0] e4);
    logic [31:0] exp_v [5];
    exp_v = '{e0, e1, e2, e3, e4};
    check({tag, "_count"}, vq.size(), exp_n);
    for (int i = 0; i < exp_n; i++) begin
      check($sformatf("%s_val%0d", tag, i), (i < vq.size()) ? 32'(vq[i]) : 32'hFFFF_FFFF, exp_v[i]);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n       = 1'b0;
    bus_if.sig_in = 1'b0;
    cyc(3);
    check("rst_period",  bus_if.period,       0);
    check("rst_valid",   bus_if.period_valid, 0);
    check("rst_timeout", bus_if.timeout,      0);
    reset_n = 1'b1;
    cyc(2);

    // Period 8: first edge silent, then four reports of 8.
    vq.delete();
    wave(4, 4, 5);
    check_vq("p8", 4, 8, 8, 8, 8, 0);
    check("p8_no_timeout", bus_if.timeout, 0);

    // Hold low: timeout sets, period keeps its value, no new reports.
    cyc(30);
    check("to_set",       bus_if.timeout, 1);
    check("to_period",    bus_if.period,  8);
    check("to_no_valid",  vq.size(),      4);

    // Next rise clears timeout without a report.
    bus_if.sig_in = 1'b1;
    cyc(4);
    bus_if.sig_in = 1'b0;
    cyc(4);
    check("to_clear",          bus_if.timeout, 0);
    check("to_clear_no_valid", vq.size(),      4);

    // Next rise exactly 20 cycles after the previous one: reported, no timeout.
    cyc(12);
    bus_if.sig_in = 1'b1;
    cyc(4);
    bus_if.sig_in = 1'b0;
    cyc(6);
    check("edge20_count",   vq.size(),      5);
    check("edge20_val",     (vq.size() == 5) ? 32'(vq[4]) : 32'hFFFF_FFFF, 20);
    check("edge20_timeout", bus_if.timeout, 0);

    // Let it time out, then change period from 8 to 12.
    cyc(30);
    vq.delete();
    wave(4, 4, 3);
    wave(6, 6, 3);
    check_vq("p8to12", 5, 8, 8, 8, 12, 12);

    // Reset in the middle of a period.
    bus_if.sig_in = 1'b1;
    cyc(4);
    bus_if.sig_in = 1'b0;
    cyc(2);
    check("pre_rst_period", bus_if.period, 12);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_period",  bus_if.period,       0);
    check("mid_rst_valid",   bus_if.period_valid, 0);
    check("mid_rst_timeout", bus_if.timeout,      0);
    cyc(2);
    reset_n = 1'b1;
    cyc(2);
    vq.delete();
    wave(4, 4, 2);
    cyc(4);
    check_vq("after_rst", 1, 8, 0, 0, 0, 0);

    // Glitch handling: a 2-cycle pulse 8 cycles after a rise, then a
    // 3-cycle pulse 16 cycles after that rise.
    bus_if.sig_in = 1'b1;
    cyc(4);
    bus_if.sig_in = 1'b0;
    cyc(4);
    vq.delete();
    bus_if.sig_in = 1'b1;
    cyc(2);
    bus_if.sig_in = 1'b0;
    cyc(6);
    bus_if.sig_in = 1'b1;
    cyc(3);
    bus_if.sig_in = 1'b0;
    cyc(8);
`ifdef GLITCH_FILTER_EN
    check_vq("glitch", 1, 16, 0, 0, 0, 0);
`else
    check_vq("glitch", 2, 8, 8, 0, 0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
